// File: rtl/pcr_restamp_pkg.sv
// Shared constants and types for the PCR restamp block: TS header offsets,
// PCR {base,ext} widths and the packet-tracking state encoding.
package pcr_restamp_pkg;

  localparam logic [7:0] TS_SYNC     = 8'h47;
  localparam int         PCR_EXT_MOD = 300;

  localparam logic [3:0] IDX_AFC      = 4'd3;
  localparam logic [3:0] IDX_AFLEN    = 4'd4;
  localparam logic [3:0] IDX_AFFLAG   = 4'd5;
  localparam logic [3:0] IDX_PCR0     = 4'd6;
  localparam logic [3:0] IDX_PCR_B10  = 4'd10;
  localparam logic [3:0] IDX_PCR_LAST = 4'd11;
  localparam logic [3:0] IDX_SAT      = 4'd12;

  localparam logic [7:0] AFLEN_MIN = 8'd7;

  localparam int PCR_BASE_W = 33;
  localparam int PCR_EXT_W  = 9;
  localparam int PCR_W      = 42;

  typedef enum logic [1:0] {
    S_IDLE,
    S_HDR,
    S_PCR
  } pkt_state_e;

  typedef struct packed {
    logic [PCR_BASE_W-1:0] base;
    logic [PCR_EXT_W-1:0]  ext;
  } pcr_t;

  // Byte 10 carries base[0], six reserved bits kept from the stream, and ext[8].
  function automatic logic [7:0] b10_merge(input pcr_t p, input logic [7:0] orig);
    return {p.base[0], orig[6:1], p.ext[8]};
  endfunction

endpackage

// File: rtl/pcr_ext_add.sv
// Registered 42-bit PCR add/subtract: ext normalised modulo EXT_MOD with
// carry/borrow into base, base wrapping modulo 2^33.
module pcr_ext_add
  import pcr_restamp_pkg::*;
#(
  parameter int EXT_MOD = PCR_EXT_MOD
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic sub,
  input  pcr_t a,
  input  pcr_t b,
  output logic done,
  output pcr_t y
);

  localparam logic [PCR_EXT_W:0] MOD_X = (PCR_EXT_W + 1)'(EXT_MOD);

  logic [PCR_EXT_W:0] ext_raw;
  logic [PCR_EXT_W:0] ext_fix;
  logic               cy;
  pcr_t               y_nxt;

  always_comb begin
    ext_raw = '0;
    ext_fix = '0;
    cy      = 1'b0;
    y_nxt   = '0;
    if (sub) begin
      ext_raw    = {1'b0, a.ext} - {1'b0, b.ext};
      cy         = (a.ext < b.ext);
      ext_fix    = cy ? ext_raw + MOD_X : ext_raw;
      y_nxt.base = a.base - b.base - PCR_BASE_W'(cy);
    end else begin
      ext_raw    = {1'b0, a.ext} + {1'b0, b.ext};
      cy         = (ext_raw >= MOD_X);
      ext_fix    = cy ? ext_raw - MOD_X : ext_raw;
      y_nxt.base = a.base + b.base + PCR_BASE_W'(cy);
    end
    y_nxt.ext = PCR_EXT_W'(ext_fix);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done <= 1'b0;
      y    <= '0;
    end else begin
      done <= start;
      if (start) y <= y_nxt;
    end
  end

endmodule

// File: rtl/pcr_restamp.sv
// Fixed-latency TS byte pipeline that rewrites the PCR field in flight with
// PCR_old + (now - arrival). `PCR_RESTAMP_CNT_EN adds pcr_cnt/pcr_err_cnt.
//
//   state  | meaning
//   S_IDLE | no candidate packet being tracked
//   S_HDR  | sync/enable ok, checking adaptation-field bytes 1..5
//   S_PCR  | capturing PCR bytes 6..11
module pcr_restamp
  import pcr_restamp_pkg::*;
#(
  parameter int LAT     = 12,
  parameter int EXT_MOD = PCR_EXT_MOD
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_restamp_en,
  input  logic [PCR_W-1:0] pcr_lo_data,
  input  logic [7:0]       ts_din,
  input  logic             ts_din_vld,
  input  logic             ts_din_sop,
  input  logic [PCR_W-1:0] ts_din_arr,
  output logic [7:0]       ts_dout,
  output logic             ts_dout_vld,
  output logic             ts_dout_sop,
  output logic             pcr_err
`ifdef PCR_RESTAMP_CNT_EN
  ,
  output logic [31:0]      pcr_cnt,
  output logic [31:0]      pcr_err_cnt
`endif
);

  pkt_state_e state_q, state_nxt;
  logic [3:0] idx_q, byte_idx;
  logic       err_set, pcr_done;

  logic [31:0] pcr_sr;
  logic        b10_msb, b10_lsb;
  logic [PCR_EXT_W-1:0] cap_ext;

  pcr_t arr_q, now_q, pcr_old_q, delta, sum;
  logic calc_start, delta_vld, sum_vld;

  logic [7:0]     pipe_data [LAT];
  logic [LAT-1:0] pipe_vld, pipe_sop;

  assign byte_idx = ts_din_sop ? 4'd0 : idx_q;
  assign cap_ext  = {b10_lsb, ts_din};

  always_comb begin
    state_nxt = state_q;
    err_set   = 1'b0;
    pcr_done  = 1'b0;
    if (ts_din_vld && ts_din_sop) begin
      err_set   = (state_q != S_IDLE);
      state_nxt = (ts_din == TS_SYNC && cfg_restamp_en) ? S_HDR : S_IDLE;
    end else if (state_q != S_IDLE && !ts_din_vld) begin
      err_set   = 1'b1;
      state_nxt = S_IDLE;
    end else if (ts_din_vld) begin
      case (state_q)
        S_HDR: begin
          if ((byte_idx == IDX_AFC    && !ts_din[5]) ||
              (byte_idx == IDX_AFLEN  && ts_din < AFLEN_MIN) ||
              (byte_idx == IDX_AFFLAG && !ts_din[4]))
            state_nxt = S_IDLE;
          else if (byte_idx == IDX_AFFLAG)
            state_nxt = S_PCR;
        end
        S_PCR: begin
          if (byte_idx == IDX_PCR_LAST) begin
            state_nxt = S_IDLE;
            if (cap_ext >= PCR_EXT_W'(EXT_MOD)) err_set  = 1'b1;
            else                                pcr_done = 1'b1;
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      pcr_err <= 1'b0;
    end else begin
      state_q <= state_nxt;
      pcr_err <= err_set;
      if (ts_din_vld) idx_q <= (byte_idx == IDX_SAT) ? IDX_SAT : byte_idx + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arr_q      <= '0;
      now_q      <= '0;
      pcr_old_q  <= '0;
      pcr_sr     <= '0;
      b10_msb    <= 1'b0;
      b10_lsb    <= 1'b0;
      calc_start <= 1'b0;
    end else begin
      calc_start <= pcr_done;
      if (ts_din_vld && ts_din_sop) arr_q <= ts_din_arr;
      if (ts_din_vld && !ts_din_sop && state_q == S_PCR && byte_idx >= IDX_PCR0) begin
        if (byte_idx < IDX_PCR_B10) pcr_sr <= {pcr_sr[23:0], ts_din};
        if (byte_idx == IDX_PCR_B10) begin
          b10_msb <= ts_din[7];
          b10_lsb <= ts_din[0];
        end
      end
      if (pcr_done) begin
        pcr_old_q <= {pcr_sr, b10_msb, cap_ext};
        now_q     <= pcr_lo_data;
      end
    end
  end

  pcr_ext_add #(.EXT_MOD(EXT_MOD)) u_delta (
    .clk   (clk),
    .rst_n (rst_n),
    .start (calc_start),
    .sub   (1'b1),
    .a     (now_q),
    .b     (arr_q),
    .done  (delta_vld),
    .y     (delta)
  );

  pcr_ext_add #(.EXT_MOD(EXT_MOD)) u_sum (
    .clk   (clk),
    .rst_n (rst_n),
    .start (delta_vld),
    .sub   (1'b0),
    .a     (pcr_old_q),
    .b     (delta),
    .done  (sum_vld),
    .y     (sum)
  );

  // When sum_vld is high, PCR bytes 6..11 are leaving stages 7..2; overwrite as they land in 8..3.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < LAT; k++) pipe_data[k] <= '0;
      pipe_vld <= '0;
      pipe_sop <= '0;
    end else begin
      pipe_data[0] <= ts_din;
      for (int k = 1; k < LAT; k++) pipe_data[k] <= pipe_data[k-1];
      pipe_vld <= {pipe_vld[LAT-2:0], ts_din_vld};
      pipe_sop <= {pipe_sop[LAT-2:0], ts_din_sop};
      if (sum_vld) begin
        pipe_data[3] <= sum.ext[7:0];
        pipe_data[4] <= b10_merge(sum, pipe_data[3]);
        pipe_data[5] <= sum.base[8:1];
        pipe_data[6] <= sum.base[16:9];
        pipe_data[7] <= sum.base[24:17];
        pipe_data[8] <= sum.base[32:25];
      end
    end
  end

  assign ts_dout     = pipe_data[LAT-1];
  assign ts_dout_vld = pipe_vld[LAT-1];
  assign ts_dout_sop = pipe_sop[LAT-1];

`ifdef PCR_RESTAMP_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcr_cnt     <= '0;
      pcr_err_cnt <= '0;
    end else begin
      if (sum_vld && pcr_cnt != '1)     pcr_cnt     <= pcr_cnt + 32'd1;
      if (pcr_err && pcr_err_cnt != '1) pcr_err_cnt <= pcr_err_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pcr_restamp.sv
// Directed bench for pcr_restamp: hand-computed PCR restamps, pass-through and
// error packets, back-to-back packets and a mid-packet reset.
module tb_pcr_restamp;

  localparam int LAT = 12;
  typedef logic [7:0] pkt_t [16];

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        cfg_restamp_en = 1'b1;
  logic [41:0] pcr_lo_data = '0;
  logic [7:0]  ts_din = '0;
  logic        ts_din_vld = 1'b0;
  logic        ts_din_sop = 1'b0;
  logic [41:0] ts_din_arr = '0;
  logic [7:0]  ts_dout;
  logic        ts_dout_vld, ts_dout_sop, pcr_err;
`ifdef PCR_RESTAMP_CNT_EN
  logic [31:0] pcr_cnt, pcr_err_cnt;
`endif

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int err_pulses = 0;
  int sop_in_cyc = 0;
  int sop_out_cyc = 0;
  logic [7:0] out_q [$];

  pcr_restamp #(.LAT(LAT)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cfg_restamp_en (cfg_restamp_en),
    .pcr_lo_data    (pcr_lo_data),
    .ts_din         (ts_din),
    .ts_din_vld     (ts_din_vld),
    .ts_din_sop     (ts_din_sop),
    .ts_din_arr     (ts_din_arr),
    .ts_dout        (ts_dout),
    .ts_dout_vld    (ts_dout_vld),
    .ts_dout_sop    (ts_dout_sop),
    .pcr_err        (pcr_err)
`ifdef PCR_RESTAMP_CNT_EN
    ,
    .pcr_cnt        (pcr_cnt),
    .pcr_err_cnt    (pcr_err_cnt)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (ts_dout_vld) begin
      out_q.push_back(ts_dout);
      if (ts_dout_sop) sop_out_cyc = cyc;
    end
    if (pcr_err) err_pulses++;
  end

  function automatic logic [41:0] pcr(input logic [32:0] b, input logic [8:0] e);
    return {b, e};
  endfunction

  function automatic pkt_t mk_pkt(input logic [7:0] sync, input logic [7:0] b3, input logic [7:0] b4,
                                  input logic [7:0] b5, input logic [32:0] base, input logic [8:0] ext,
                                  input logic [5:0] rsv);
    pkt_t p;
    p[0] = sync; p[1] = 8'h01; p[2] = 8'h23; p[3] = b3; p[4] = b4; p[5] = b5;
    p[6] = base[32:25]; p[7] = base[24:17]; p[8] = base[16:9]; p[9] = base[8:1];
    p[10] = {base[0], rsv, ext[8]};
    p[11] = ext[7:0];
    for (int i = 12; i < 16; i++) p[i] = 8'hC0 + 8'(i);
    return p;
  endfunction

  function automatic pkt_t cand(input logic [32:0] base, input logic [8:0] ext, input logic [5:0] rsv);
    return mk_pkt(8'h47, 8'h30, 8'd7, 8'h10, base, ext, rsv);
  endfunction

  function automatic logic [127:0] pk(input pkt_t p);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = p[i];
    return r;
  endfunction

  function automatic logic [127:0] outpk(input int off);
    logic [127:0] r;
    r = 'x;
    for (int i = 0; i < 16; i++)
      if (off + i < out_q.size()) r[127-8*i -: 8] = out_q[off+i];
    return r;
  endfunction

  task automatic tick_idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      ts_din_vld = 1'b0; ts_din_sop = 1'b0; ts_din = '0;
    end
  endtask

  task automatic drive(input logic [7:0] d, input logic sop, input logic [41:0] arr);
    @(posedge clk); #1;
    ts_din = d; ts_din_vld = 1'b1; ts_din_sop = sop; ts_din_arr = arr;
    if (sop) sop_in_cyc = cyc;
  endtask

  task automatic send_pkt(input pkt_t p, input logic [41:0] arr, input logic [41:0] now_v,
                          input int nbytes, input int gap_at);
    pcr_lo_data = now_v;
    for (int i = 0; i < nbytes; i++) begin
      if (i == gap_at) tick_idle(1);
      drive(p[i], i == 0, arr);
    end
  endtask

  task automatic flush();
    out_q.delete();
    err_pulses = 0;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({ts_dout, ts_dout_vld, ts_dout_sop, pcr_err} !== 11'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %h exp 000", {ts_dout, ts_dout_vld, ts_dout_sop, pcr_err});
    end
`ifdef PCR_RESTAMP_CNT_EN
    checks++;
    if ({pcr_cnt, pcr_err_cnt} !== 64'd0) begin
      errors++;
      $display("FAIL reset_counters: got %h exp 0", {pcr_cnt, pcr_err_cnt});
    end
`endif
    @(posedge clk); #1 rst_n = 1'b1;
    tick_idle(2);
  endtask

  task automatic test_restamp_basic();
    pkt_t p, e;
    flush();
    p = cand(33'd5000, 9'd200, 6'h15);
    e = cand(33'd5001, 9'd50, 6'h15);
    send_pkt(p, pcr(33'd1000, 9'd100), pcr(33'd1000, 9'd250), 16, -1);
    tick_idle(LAT + 6);
    checks++;
    if (out_q.size() !== 16) begin errors++; $display("FAIL basic_len: got %0d exp 16", out_q.size()); end
    checks++;
    if (outpk(0) !== pk(e)) begin errors++; $display("FAIL basic_bytes: got %h exp %h", outpk(0), pk(e)); end
    checks++;
    if (sop_out_cyc - sop_in_cyc !== LAT) begin
      errors++; $display("FAIL basic_latency: got %0d exp %0d", sop_out_cyc - sop_in_cyc, LAT);
    end
    checks++;
    if (err_pulses !== 0) begin errors++; $display("FAIL basic_err: got %0d exp 0", err_pulses); end
  endtask

  task automatic test_wrap();
    pkt_t p, e;
    flush();
    p = cand(33'h1_FFFF_FFFF, 9'd299, 6'h3F);
    e = cand(33'd0, 9'd0, 6'h3F);
    send_pkt(p, pcr(33'd7, 9'd10), pcr(33'd7, 9'd11), 16, -1);
    tick_idle(LAT + 6);
    checks++;
    if (outpk(0) !== pk(e)) begin errors++; $display("FAIL wrap_bytes: got %h exp %h", outpk(0), pk(e)); end
    checks++;
    if (err_pulses !== 0) begin errors++; $display("FAIL wrap_err: got %0d exp 0", err_pulses); end
  endtask

  task automatic test_borrow();
    pkt_t p, e;
    flush();
    p = cand(33'd0, 9'd0, 6'h2A);
    e = cand(33'd0, 9'd15, 6'h2A);
    send_pkt(p, pcr(33'd10, 9'd290), pcr(33'd11, 9'd5), 16, -1);
    tick_idle(LAT + 6);
    checks++;
    if (outpk(0) !== pk(e)) begin errors++; $display("FAIL borrow_bytes: got %h exp %h", outpk(0), pk(e)); end
  endtask

  task automatic test_passthrough();
    pkt_t pkts [4];
    pkts[0] = mk_pkt(8'h47, 8'h30, 8'd7, 8'h00, 33'd123, 9'd45, 6'h01);
    pkts[1] = mk_pkt(8'h47, 8'h30, 8'd0, 8'h10, 33'd123, 9'd45, 6'h02);
    pkts[2] = mk_pkt(8'h48, 8'h30, 8'd7, 8'h10, 33'd123, 9'd45, 6'h03);
    pkts[3] = cand(33'd123, 9'd45, 6'h04);
    for (int k = 0; k < 4; k++) begin
      flush();
      cfg_restamp_en = (k != 3);
      send_pkt(pkts[k], pcr(33'd1000, 9'd100), pcr(33'd1000, 9'd250), 16, -1);
      tick_idle(LAT + 6);
      checks++;
      if (outpk(0) !== pk(pkts[k])) begin
        errors++; $display("FAIL pass%0d_bytes: got %h exp %h", k, outpk(0), pk(pkts[k]));
      end
      checks++;
      if (err_pulses !== 0) begin errors++; $display("FAIL pass%0d_err: got %0d exp 0", k, err_pulses); end
    end
    cfg_restamp_en = 1'b1;
  endtask

  task automatic test_errors();
    pkt_t a, b, be, x;
    logic [127:0] got, exp_v;
    // vld gap before idx 8
    flush();
    a = cand(33'd5000, 9'd200, 6'h11);
    send_pkt(a, pcr(33'd1000, 9'd100), pcr(33'd1000, 9'd250), 16, 8);
    tick_idle(LAT + 6);
    checks++;
    if (outpk(0) !== pk(a)) begin errors++; $display("FAIL gap_bytes: got %h exp %h", outpk(0), pk(a)); end
    checks++;
    if (err_pulses !== 1) begin errors++; $display("FAIL gap_err: got %0d exp 1", err_pulses); end
    // second sop at idx 9; the new packet is still restamped
    flush();
    a = cand(33'd700, 9'd10, 6'h05);
    b = cand(33'd5000, 9'd200, 6'h15);
    be = cand(33'd5001, 9'd50, 6'h15);
    send_pkt(a, pcr(33'd1, 9'd1), pcr(33'd2, 9'd2), 9, -1);
    send_pkt(b, pcr(33'd1000, 9'd100), pcr(33'd1000, 9'd250), 16, -1);
    tick_idle(LAT + 6);
    checks++;
    if (out_q.size() !== 25) begin errors++; $display("FAIL sop2_len: got %0d exp 25", out_q.size()); end
    got = outpk(0);
    exp_v = pk(a);
    checks++;
    if (got[127:56] !== exp_v[127:56]) begin
      errors++; $display("FAIL sop2_first: got %h exp %h", got[127:56], exp_v[127:56]);
    end
    checks++;
    if (outpk(9) !== pk(be)) begin errors++; $display("FAIL sop2_second: got %h exp %h", outpk(9), pk(be)); end
    checks++;
    if (err_pulses !== 1) begin errors++; $display("FAIL sop2_err: got %0d exp 1", err_pulses); end
    // illegal captured ext
    flush();
    x = cand(33'd100, 9'd300, 6'h00);
    send_pkt(x, pcr(33'd1000, 9'd100), pcr(33'd1000, 9'd250), 16, -1);
    tick_idle(LAT + 6);
    checks++;
    if (outpk(0) !== pk(x)) begin errors++; $display("FAIL ext300_bytes: got %h exp %h", outpk(0), pk(x)); end
    checks++;
    if (err_pulses !== 1) begin errors++; $display("FAIL ext300_err: got %0d exp 1", err_pulses); end
  endtask

  task automatic test_back_to_back();
    pkt_t p1, p2, e1, e2;
    flush();
    p1 = cand(33'd5000, 9'd200, 6'h15);
    e1 = cand(33'd5001, 9'd50, 6'h15);
    p2 = cand(33'd0, 9'd0, 6'h2A);
    e2 = cand(33'd0, 9'd15, 6'h2A);
    send_pkt(p1, pcr(33'd1000, 9'd100), pcr(33'd1000, 9'd250), 16, -1);
    send_pkt(p2, pcr(33'd10, 9'd290), pcr(33'd11, 9'd5), 16, -1);
    tick_idle(LAT + 6);
    checks++;
    if (outpk(0) !== pk(e1)) begin errors++; $display("FAIL b2b_first: got %h exp %h", outpk(0), pk(e1)); end
    checks++;
    if (outpk(16) !== pk(e2)) begin errors++; $display("FAIL b2b_second: got %h exp %h", outpk(16), pk(e2)); end
    checks++;
    if (err_pulses !== 0) begin errors++; $display("FAIL b2b_err: got %0d exp 0", err_pulses); end
  endtask

  task automatic test_reset_mid();
    pkt_t p, e;
    p = cand(33'd5000, 9'd200, 6'h15);
    e = cand(33'd5001, 9'd50, 6'h15);
    flush();
    send_pkt(p, pcr(33'd1000, 9'd100), pcr(33'd1000, 9'd250), 8, -1);
    rst_n = 1'b0;
    ts_din_vld = 1'b0; ts_din_sop = 1'b0;
    @(negedge clk);
    checks++;
    if ({ts_dout, ts_dout_vld, ts_dout_sop, pcr_err} !== 11'b0) begin
      errors++;
      $display("FAIL midrst_outputs: got %h exp 000", {ts_dout, ts_dout_vld, ts_dout_sop, pcr_err});
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick_idle(LAT + 4);
    checks++;
    if (out_q.size() !== 0) begin errors++; $display("FAIL midrst_dropped: got %0d exp 0", out_q.size()); end
    flush();
    send_pkt(p, pcr(33'd1000, 9'd100), pcr(33'd1000, 9'd250), 16, -1);
    tick_idle(LAT + 6);
    checks++;
    if (outpk(0) !== pk(e)) begin errors++; $display("FAIL midrst_bytes: got %h exp %h", outpk(0), pk(e)); end
    checks++;
    if (err_pulses !== 0) begin errors++; $display("FAIL midrst_err: got %0d exp 0", err_pulses); end
`ifdef PCR_RESTAMP_CNT_EN
    checks++;
    if (pcr_cnt !== 32'd1) begin errors++; $display("FAIL midrst_pcr_cnt: got %0d exp 1", pcr_cnt); end
    checks++;
    if (pcr_err_cnt !== 32'd0) begin errors++; $display("FAIL midrst_err_cnt: got %0d exp 0", pcr_err_cnt); end
`endif
  endtask

  initial begin
    test_reset();
    test_restamp_basic();
    test_wrap();
    test_borrow();
    test_passthrough();
    test_errors();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
